// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one unified ram between the instruction-fetch
// port and the load/store port, one access at a time, with a fixed latency.
module mem_arbiter #(
  parameter int MEM_LAT = 1  // legal 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_adr,
  output logic        mem_load,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state, state_nxt;
  owner_t     owner, last_owner;
  logic [3:0] cnt;
  logic       we_q;
  logic       if_wins;

  // Fetch wins when it is alone, or when data held the ram last time.
  assign if_wins = if_req && (!d_req || last_owner == OWN_D);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    unique case (state)
      IDLE: begin
        // Grants are combinational; gating with reset keeps every output low
        // while reset is held.
        if (!reset) begin
          if (if_wins)    if_gnt = 1'b1;
          else if (d_req) d_gnt  = 1'b1;
        end
        if (if_gnt || d_gnt) state_nxt = BUSY;
      end
      BUSY:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_D;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      mem_adr    <= '0;
      mem_in     <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (if_gnt || d_gnt) begin
            owner      <= if_gnt ? OWN_IF : OWN_D;
            last_owner <= if_gnt ? OWN_IF : OWN_D;
            mem_adr    <= if_gnt ? if_adr : d_adr;
            we_q       <= d_gnt && d_we;  // fetch port is read-only
            cnt        <= LAT;
            if (d_gnt) mem_in <= d_wdata;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1 && !we_q) begin
            if (owner == OWN_IF) if_rdata <= mem_out;
            else                 d_rdata  <= mem_out;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobe only in the first BUSY cycle: exactly one write per store. It is
  // decoded from the async-reset state, so reset drops it immediately.
  assign mem_load  = (state == BUSY) && (cnt == LAT) && we_q;
  assign if_rvalid = (state == RESP) && (owner == OWN_IF);
  assign d_rvalid  = (state == RESP) && (owner == OWN_D);
  assign busy      = (state != IDLE);

endmodule
